// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU execute-stage arithmetic blocks.
//   DATA_W   : default operand/result width (two's complement)
//   SAT_MAX  : most positive DATA_W-bit value; the positive-overflow result
//   SAT_MIN  : most negative DATA_W-bit value; the negative-overflow result
//   sub_state_t : state encoding of the serial subtractor
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/cla_slice.sv
// ----------------------------------------------------------------------------
// cla_slice
// Combinational SLICE_W-bit carry-lookahead adder: s = x + y + cin.
// Ports:
//   x, y : addend slices
//   cin  : carry into bit 0
//   s    : sum slice
//   cout : carry out of the top bit
// ----------------------------------------------------------------------------
module cla_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    always_comb begin
        logic [SLICE_W-1:0] g;
        logic [SLICE_W-1:0] p;
        logic [SLICE_W:0]   c;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        // Generate/propagate recurrence; unrolled, each carry becomes a
        // flat sum-of-products of g, p and cin.
        for (int i = 0; i < SLICE_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s    = p ^ c[SLICE_W-1:0];
        cout = c[SLICE_W];
    end

endmodule

// File: rtl/alu_sub_serial.sv
// ----------------------------------------------------------------------------
// alu_sub_serial
// Multi-cycle saturating signed subtractor. Computes a - b as a + ~b + 1, one
// SLICE_W-bit slice per cycle with the carry registered between slices, then
// saturates on signed overflow. Flag and saturation semantics match the adder.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready : operand handshake; in_ready is high only in IDLE
//   a, b                : minuend / subtrahend, captured on in_valid&&in_ready
//   out_valid/out_ready : result handshake; out_valid is high only in DONE
//   result              : saturated difference
//   ovfl, zero, sign    : overflow (saturated), result==0, result MSB
// ----------------------------------------------------------------------------
module alu_sub_serial #(
    parameter int DATA_W  = alu_pkg::DATA_W,
    parameter int SLICE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              ovfl,
    output logic              zero,
    output logic              sign
);

    import alu_pkg::*;

    // DATA_W must be a multiple of SLICE_W.
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int IDX_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

    // Saturation limits for this instance's width.
    localparam logic signed [DATA_W-1:0] LIM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] LIM_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    sub_state_t state, state_nxt;

    logic [CNT_W-1:0]         cnt;
    logic                     carry;
    logic signed [DATA_W-1:0] a_op;
    logic signed [DATA_W-1:0] nb_op;
    logic signed [DATA_W-1:0] part_sum;
    logic signed [DATA_W-1:0] raw_diff;
    logic [IDX_W-1:0]         base;
    logic [SLICE_W-1:0]       sl_x, sl_y, sl_s;
    logic                     sl_cout;
    logic [DATA_W:0]          sat;
    logic signed [DATA_W-1:0] result_r;
    logic                     ovfl_r, zero_r, sign_r;

    // Returns {ovfl, value}. Overflow is only possible when the operand
    // signs differ and the raw difference takes the subtrahend's sign.
    function automatic logic [DATA_W:0] saturate(
        input logic signed [DATA_W-1:0] raw,
        input logic                     a_msb,
        input logic                     b_msb
    );
        logic of;
        of = (a_msb != b_msb) && (raw[DATA_W-1] != a_msb);
        if (!of)
            return {1'b0, raw};
        else if (a_msb)
            return {1'b1, LIM_MIN};
        else
            return {1'b1, LIM_MAX};
    endfunction

    // ---- Control: state register ----
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: begin
                if (cnt == LAST_SLICE) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- Slice datapath: one CLA slice, selected by the counter ----
    cla_slice #(.SLICE_W(SLICE_W)) u_slice (
        .x    (sl_x),
        .y    (sl_y),
        .cin  (carry),
        .s    (sl_s),
        .cout (sl_cout)
    );

    always_comb begin
        base     = IDX_W'(cnt) * IDX_W'(SLICE_W);
        sl_x     = a_op[base +: SLICE_W];
        sl_y     = nb_op[base +: SLICE_W];
        // Partial sum with the current slice merged in; on the last slice
        // this is the complete raw difference.
        raw_diff = part_sum;
        raw_diff[base +: SLICE_W] = sl_s;
        sat      = saturate(raw_diff, a_op[DATA_W-1], ~nb_op[DATA_W-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            result_r <= '0;
            ovfl_r   <= 1'b0;
            zero_r   <= 1'b0;
            sign_r   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt   <= '0;
                        carry <= 1'b1;   // the +1 of a + ~b + 1
                    end
                end
                CALC: begin
                    carry <= sl_cout;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_SLICE) begin
                        ovfl_r   <= sat[DATA_W];
                        result_r <= sat[DATA_W-1:0];
                        zero_r   <= (sat[DATA_W-1:0] == '0);
                        sign_r   <= sat[DATA_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand and partial-sum registers carry no reset; they are always
    // rewritten before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_op  <= a;
            nb_op <= ~b;
        end
        if (state == CALC) begin
            part_sum <= raw_diff;
        end
    end

    assign result = result_r;
    assign ovfl   = ovfl_r;
    assign zero   = zero_r;
    assign sign   = sign_r;

endmodule

// File: tb/tb_alu_sub_serial.sv
module tb_alu_sub_serial;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] res;
        logic          ovfl;
        logic          zero;
        logic          sign;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a, b;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] result;
    logic          ovfl, zero, sign;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    alu_sub_serial #(.DATA_W(DW), .SLICE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovfl      (ovfl),
        .zero      (zero),
        .sign      (sign)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer difference, clamped to the 16-bit signed range.
    function automatic exp_t model(input logic [DW-1:0] x, input logic [DW-1:0] y);
        exp_t e;
        int   d;
        d = int'($signed(x)) - int'($signed(y));
        if (d > 32767) begin
            e.res = 16'h7FFF; e.ovfl = 1'b1;
        end else if (d < -32768) begin
            e.res = 16'h8000; e.ovfl = 1'b1;
        end else begin
            e.res = d[DW-1:0]; e.ovfl = 1'b0;
        end
        e.zero = (e.res == 16'h0000);
        e.sign = e.res[DW-1];
        return e;
    endfunction

    // Wait (bounded) for in_ready, present operands for one accept edge.
    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int g = 0;
        while (!in_ready && g < 20) begin tick(); g++; end
        check("in_ready_wait", 32'(g < 20), 32'd1);
        a = x; b = y; in_valid = 1'b1;
        sb.push_back(model(x, y));
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for out_valid while scrambling the operand inputs, check latency
    // and the popped expectation.
    task automatic receive(input string tag);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 20) begin
            a = DW'($urandom); b = DW'($urandom);
            tick(); lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e.res));
            check({tag, "_ovfl"},   32'(ovfl),   32'(e.ovfl));
            check({tag, "_zero"},   32'(zero),   32'(e.zero));
            check({tag, "_sign"},   32'(sign),   32'(e.sign));
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready",  32'(in_ready),  32'd1);
    endtask

    task automatic do_op(input string tag, input logic [DW-1:0] x, input logic [DW-1:0] y);
        send(x, y);
        receive(tag);
        release_out();
    endtask

    initial begin
        logic [DW-1:0] hold_res;
        logic          hold_ovfl, hold_zero, hold_sign;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result",    32'(result),    32'd0);
        check("reset_flags",     32'({ovfl, zero, sign}), 32'd0);

        do_op("basic",       16'h0005, 16'h0003);
        do_op("neg_sat",     16'h8000, 16'h0001);
        do_op("pos_sat",     16'h7FFF, 16'hFFFF);
        do_op("zero_minus_min", 16'h0000, 16'h8000);
        do_op("equal",       16'h1234, 16'h1234);
        do_op("borrow",      16'h0000, 16'h0001);
        do_op("min_minus_min", 16'h8000, 16'h8000);
        do_op("neg_no_ovfl", 16'h8000, 16'hFFFF);
        for (int i = 0; i < 6; i++) begin
            do_op("random", DW'($urandom), DW'($urandom));
        end

        // Stall in DONE: outputs frozen, operand pulses ignored.
        send(16'h0100, 16'h0300);
        receive("stall");
        hold_res = result; hold_ovfl = ovfl; hold_zero = zero; hold_sign = sign;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; a = DW'($urandom); b = DW'($urandom);
            tick();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_outputs",   32'({result, ovfl, zero, sign}),
                                     32'({hold_res, hold_ovfl, hold_zero, hold_sign}));
        end
        in_valid = 1'b0;
        release_out();
        do_op("after_stall", 16'h0042, 16'h0040);

        // Reset during the second CALC cycle discards the operation.
        a = 16'h7000; b = 16'h0123; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result",    32'(result),    32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_output", 32'(out_valid), 32'd0);
        end
        do_op("after_abort", 16'h0010, 16'h0001);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
